// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch, data and memory handshakes of the shared memory port.
// master: the arbiter's view. slave: the view of the requesters and memory
// that surround it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_inst;
    logic              im_ack;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              bus_err;

    modport master (
        input  im_req, im_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output im_inst, im_ack,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output bus_err
    );

    modport slave (
        output im_req, im_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  im_inst, im_ack,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch (IM) and data access (DM).
// The winner's request is latched and held on the memory side until mem_ack,
// then a one-cycle ack with the read data goes back to the winner. A watchdog
// closes any transfer the memory leaves unanswered and flags it on bus_err.
//
// state | meaning
// IDLE  | no transfer open; arbitrate on the next request seen
// XFER  | mem_req held with frozen address/data; waiting for mem_ack or timeout
// RESP  | winner's ack (and bus_err on timeout) high for this one cycle
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t             state_q, state_d;
    logic               grant_dm_q, grant_dm_d;
    logic               last_dm_q, last_dm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  im_inst_q, im_inst_d;
    logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
    logic               im_ack_q, im_ack_d;
    logic               dm_ack_q, dm_ack_d;
    logic               bus_err_q, bus_err_d;
    logic               pick_dm;

    // DM wins contention unless it won the previous grant, so both sides alternate.
    assign pick_dm = bus.dm_req && (!bus.im_req || !last_dm_q);

    // Next state and next value of every registered output.
    always_comb begin
        state_d     = state_q;
        grant_dm_d  = grant_dm_q;
        last_dm_d   = last_dm_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        im_inst_d   = im_inst_q;
        dm_rdata_d  = dm_rdata_q;
        im_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.im_req || bus.dm_req) begin
                    grant_dm_d  = pick_dm;
                    last_dm_d   = pick_dm;
                    mem_addr_d  = pick_dm ? bus.dm_addr : bus.im_addr;
                    mem_we_d    = pick_dm && bus.dm_we;
                    mem_wdata_d = pick_dm ? bus.dm_wdata : '0;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (bus.mem_ack) begin
                    if (grant_dm_q) dm_rdata_d = bus.mem_rdata;
                    else            im_inst_d  = bus.mem_rdata;
                    im_ack_d  = !grant_dm_q;
                    dm_ack_d  = grant_dm_q;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    if (grant_dm_q) dm_rdata_d = '0;
                    else            im_inst_d  = '0;
                    im_ack_d  = !grant_dm_q;
                    dm_ack_d  = grant_dm_q;
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops an open transfer without an ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_dm_q  <= 1'b0;
            last_dm_q   <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            im_inst_q   <= '0;
            dm_rdata_q  <= '0;
            im_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_dm_q  <= grant_dm_d;
            last_dm_q   <= last_dm_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            im_inst_q   <= im_inst_d;
            dm_rdata_q  <= dm_rdata_d;
            im_ack_q    <= im_ack_d;
            dm_ack_q    <= dm_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.im_inst   = im_inst_q;
    assign bus.im_ack    = im_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized transfers against a small transaction-level model:
// the model predicts the winner from the alternation rule, the latched memory
// request, the returned data and the watchdog outcome of each transfer.
module tb_mem_bus_arbiter;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Model state
    bit          m_last_dm;
    logic [31:0] m_im_inst;
    logic [31:0] m_dm_rdata;
    bit          in_resp;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cycles, input bit stray);
        bus.im_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (cycles) begin
            bus.mem_ack = stray & 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_quiet", {60'd0, bus.mem_req, bus.im_ack, bus.dm_ack, bus.bus_err}, 64'd0);
        end
        bus.mem_ack = 1'b0;
    endtask

    // One complete transfer. Starts at a negedge in IDLE (or in RESP when the
    // previous transfer kept its requests up) and ends at the RESP negedge
    // (keep=1) or the following IDLE negedge (keep=0).
    task automatic txn(input bit ir, input bit dr, input bit we,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int dly, input bit keep, input bit stray);
        bit          exp_dm;
        bit          tmo;
        int          n;
        logic [31:0] exp_addr;
        bit          exp_we;

        exp_dm    = dr && (!ir || !m_last_dm);
        m_last_dm = exp_dm;
        tmo       = (dly >= TIMEOUT);
        exp_addr  = exp_dm ? da : ia;
        exp_we    = exp_dm && we;

        bus.im_req   = ir;
        bus.dm_req   = dr;
        bus.im_addr  = ia;
        bus.dm_addr  = da;
        bus.dm_we    = we;
        bus.dm_wdata = wd;
        bus.mem_ack  = stray;

        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && in_resp)
                chk("ack_single_cycle", {62'd0, bus.im_ack, bus.dm_ack}, 64'd0);
        end while (bus.mem_req !== 1'b1 && n < 4);
        bus.mem_ack = 1'b0;
        chk("grant_latency", 64'(n), in_resp ? 64'd2 : 64'd1);
        chk("grant_addr", 64'(bus.mem_addr), 64'(exp_addr));
        chk("grant_we", 64'(bus.mem_we), 64'(exp_we));
        if (exp_dm) chk("grant_wdata", 64'(bus.mem_wdata), 64'(wd));
        chk("no_early_ack", {62'd0, bus.im_ack, bus.dm_ack}, 64'd0);

        // Requester-side changes during the transfer must not reach memory.
        bus.im_addr  = $urandom;
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
        bus.dm_we    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
            bus.im_req = 1'b0;
            bus.dm_req = 1'b0;
        end

        if (!tmo) begin
            repeat (dly) @(negedge clk);
            chk("xfer_hold", {31'd0, bus.mem_req, bus.mem_addr}, {31'd0, 1'b1, exp_addr});
            chk("xfer_frozen_we", 64'(bus.mem_we), 64'(exp_we));
            if (exp_dm) chk("xfer_frozen_wdata", 64'(bus.mem_wdata), 64'(wd));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end else begin
            n = 0;
            while (bus.mem_req === 1'b1 && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk("timeout_cycles", 64'(n), 64'(TIMEOUT));
        end

        if (exp_dm) m_dm_rdata = tmo ? 32'd0 : rd;
        else        m_im_inst  = tmo ? 32'd0 : rd;
        chk("resp_acks", {62'd0, bus.im_ack, bus.dm_ack}, {62'd0, !exp_dm, exp_dm});
        chk("resp_bus_err", 64'(bus.bus_err), 64'(tmo));
        chk("resp_mem_req", 64'(bus.mem_req), 64'd0);
        chk("resp_im_inst", 64'(bus.im_inst), 64'(m_im_inst));
        chk("resp_dm_rdata", 64'(bus.dm_rdata), 64'(m_dm_rdata));

        if (keep) begin
            in_resp = 1'b1;
        end else begin
            bus.im_req  = 1'b0;
            bus.dm_req  = 1'b0;
            bus.mem_ack = stray;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            chk("post_resp_quiet", {60'd0, bus.mem_req, bus.im_ack, bus.dm_ack, bus.bus_err}, 64'd0);
            in_resp = 1'b0;
        end
    endtask

    initial begin
        bit          ir, dr, keep;
        int          pat, dly;

        checks     = 0;
        failures   = 0;
        m_last_dm  = 1'b0;
        m_im_inst  = '0;
        m_dm_rdata = '0;
        in_resp    = 1'b0;

        rst           = 1'b0;
        bus.im_req    = 1'b0;
        bus.im_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset values
        #1;
        chk("reset_ctrl", {58'd0, bus.mem_req, bus.mem_we, bus.im_ack, bus.dm_ack, bus.bus_err, 1'b0}, 64'd0);
        chk("reset_data", {bus.im_inst, bus.dm_rdata}, 64'd0);
        chk("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(2, 1'b1);

        // Fetch only
        txn(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h03C02983, 2, 1'b0, 1'b0);

        // Held contention alternates DM, IM, DM, IM
        for (int i = 0; i < 4; i++)
            txn(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h0,
                32'hA000_0000 + 32'(i), 1, (i != 3), 1'b0);

        // Data write with wdata changed during the transfer
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'hDEADBEEF, 32'h1234_5678, 3, 1'b0, 1'b0);

        // Watchdog, then a normal fetch
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 32'h5555_AAAA, TIMEOUT, 1'b0, 1'b0);
        txn(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b0);

        // Stray mem_ack in IDLE, RESP and on the grant edge
        idle(3, 1'b1);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h7777_0001, 1, 1'b0, 1'b1);

        // Reset in the middle of a transfer
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h300;
        @(negedge clk);
        chk("pre_reset_mem_req", 64'(bus.mem_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_ctrl", {60'd0, bus.mem_req, bus.im_ack, bus.dm_ack, bus.bus_err}, 64'd0);
        chk("async_reset_data", {bus.im_inst, bus.dm_rdata}, 64'd0);
        bus.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_no_ack", {62'd0, bus.im_ack, bus.dm_ack}, 64'd0);
        rst        = 1'b1;
        m_last_dm  = 1'b0;
        m_im_inst  = '0;
        m_dm_rdata = '0;
        in_resp    = 1'b0;
        idle(2, 1'b0);
        txn(1'b1, 1'b1, 1'b0, 32'h20, 32'h24, 32'h0, 32'hCAFE_0001, 1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            pat  = $urandom_range(0, 2);
            ir   = (pat != 1);
            dr   = (pat != 0);
            dly  = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 5);
            keep = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            txn(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                dly, keep, 1'($urandom_range(0, 1)));
            if (!keep && $urandom_range(0, 1) == 1)
                idle($urandom_range(1, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
